// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC rotation engine.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        ITER,
        DONE
    } state_e;

    localparam int CORDIC_ITERS_MAX  = 16;
    localparam int CORDIC_ROM_AW     = 5;
    localparam int CORDIC_Z_LSB_EXP  = -15;
    localparam int CORDIC_INV_K_Q15  = 19898;
    localparam int CORDIC_K_Q15      = 53963;

endpackage

// File: rtl/cordic_iter_ctrl_if.sv
// Requester-side handshake and operand/result bundle of the CORDIC engine.
interface cordic_iter_ctrl_if #(
    parameter int XY_W = 18,
    parameter int Z_W  = 18
);
    logic                   start;
    logic signed [Z_W-1:0]  angle_in;
    logic signed [XY_W-1:0] x_in;
    logic signed [XY_W-1:0] y_in;
    logic                   ready;
    logic                   busy;
    logic                   done;
    logic signed [XY_W-1:0] x_out;
    logic signed [XY_W-1:0] y_out;
    logic signed [Z_W-1:0]  z_out;

    modport master (
        output start, angle_in, x_in, y_in,
        input  ready, busy, done, x_out, y_out, z_out
    );

    modport slave (
        input  start, angle_in, x_in, y_in,
        output ready, busy, done, x_out, y_out, z_out
    );
endinterface

// File: rtl/cordic_microrot.sv
// One combinational rotation-mode CORDIC micro-rotation; direction follows the sign of z.
module cordic_microrot #(
    parameter int XY_W   = 18,
    parameter int Z_W    = 18,
    parameter int ROM_DW = 16,
    parameter int SH_W   = 4
) (
    input  logic signed [XY_W-1:0] x_i,
    input  logic signed [XY_W-1:0] y_i,
    input  logic signed [Z_W-1:0]  z_i,
    input  logic [SH_W-1:0]        shift_i,
    input  logic [ROM_DW-1:0]      atan_i,
    output logic signed [XY_W-1:0] x_o,
    output logic signed [XY_W-1:0] y_o,
    output logic signed [Z_W-1:0]  z_o
);
    logic signed [XY_W-1:0] x_sh;
    logic signed [XY_W-1:0] y_sh;
    logic signed [Z_W-1:0]  atan_z;

    always_comb begin
        x_sh   = x_i >>> shift_i;
        y_sh   = y_i >>> shift_i;
        atan_z = $signed({{(Z_W-ROM_DW){1'b0}}, atan_i});
        if (!z_i[Z_W-1]) begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_z;
        end else begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_z;
        end
    end
endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC engine: FSM, iteration counter, arctan ROM address pipeline and result registers.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int ITERS  = 16,
    parameter int XY_W   = 18,
    parameter int Z_W    = 18,
    parameter int ROM_DW = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cordic_iter_ctrl_if.slave        req,
    output logic                     rom_en,
    output logic [CORDIC_ROM_AW-1:0] rom_addr,
    input  logic [ROM_DW-1:0]        rom_data
);
    localparam int CNT_W = 4;

    if (ITERS < 1 || ITERS > CORDIC_ITERS_MAX) begin : g_iters_range
        $error("cordic_iter_ctrl: ITERS must be in 1..16");
    end

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [XY_W-1:0]   x_q, x_d, y_q, y_d;
    logic signed [Z_W-1:0]    z_q, z_d;
    logic                     rom_en_q, rom_en_d;
    logic [CORDIC_ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic signed [XY_W-1:0]   x_out_q, x_out_d, y_out_q, y_out_d;
    logic signed [Z_W-1:0]    z_out_q, z_out_d;
    logic signed [XY_W-1:0]   x_rot, y_rot;
    logic signed [Z_W-1:0]    z_rot;

    cordic_microrot #(
        .XY_W   (XY_W),
        .Z_W    (Z_W),
        .ROM_DW (ROM_DW),
        .SH_W   (CNT_W)
    ) u_microrot (
        .x_i     (x_q),
        .y_i     (y_q),
        .z_i     (z_q),
        .shift_i (cnt_q),
        .atan_i  (rom_data),
        .x_o     (x_rot),
        .y_o     (y_rot),
        .z_o     (z_rot)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        rom_en_d   = 1'b0;
        rom_addr_d = '0;
        x_out_d    = x_out_q;
        y_out_d    = y_out_q;
        z_out_d    = z_out_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (req.start) begin
                    state_d  = PRIME;
                    x_d      = req.x_in;
                    y_d      = req.y_in;
                    z_d      = req.angle_in;
                    cnt_d    = '0;
                    rom_en_d = 1'b1;
                end
            end
            PRIME: begin
                state_d    = ITER;
                rom_en_d   = 1'b1;
                rom_addr_d = CORDIC_ROM_AW'(1);
            end
            ITER: begin
                x_d   = x_rot;
                y_d   = y_rot;
                z_d   = z_rot;
                cnt_d = cnt_q + CNT_W'(1);
                // Address runs two ahead of the rotation being applied to hide the ROM latency.
                if (int'(cnt_q) + 2 < ITERS) begin
                    rom_en_d   = 1'b1;
                    rom_addr_d = CORDIC_ROM_AW'(cnt_q) + CORDIC_ROM_AW'(2);
                end
                if (int'(cnt_q) == ITERS - 1) begin
                    state_d = DONE;
                    x_out_d = x_rot;
                    y_out_d = y_rot;
                    z_out_d = z_rot;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            x_out_q    <= '0;
            y_out_q    <= '0;
            z_out_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            x_out_q    <= x_out_d;
            y_out_q    <= y_out_d;
            z_out_q    <= z_out_d;
        end
    end

    assign req.ready = (state_q == IDLE) || (state_q == DONE);
    assign req.busy  = (state_q == PRIME) || (state_q == ITER);
    assign req.done  = (state_q == DONE);
    assign req.x_out = x_out_q;
    assign req.y_out = y_out_q;
    assign req.z_out = z_out_q;
    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: arctan ROM model, per-cycle behavioural reference, directed and random operations.
module tb_cordic_iter_ctrl;
    import cordic_pkg::*;

    localparam int ITERS  = 16;
    localparam int XY_W   = 18;
    localparam int Z_W    = 18;
    localparam int ROM_DW = 16;
    localparam int LAT    = ITERS + 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     rom_en;
    logic [CORDIC_ROM_AW-1:0] rom_addr;
    logic [ROM_DW-1:0]        rom_data = '0;

    int n_chk  = 0;
    int n_fail = 0;

    int atan_tab [16] = '{25736, 15193, 8027, 4075, 2045, 1024, 512, 256,
                          128, 64, 32, 16, 8, 4, 2, 1};

    cordic_iter_ctrl_if #(.XY_W(XY_W), .Z_W(Z_W)) bus ();

    cordic_iter_ctrl #(
        .ITERS  (ITERS),
        .XY_W   (XY_W),
        .Z_W    (Z_W),
        .ROM_DW (ROM_DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, one-cycle latency, reads 0 when not enabled.
    always @(posedge clk) begin
        rom_data <= rom_en ? ROM_DW'(atan_tab[rom_addr[3:0]]) : '0;
    end

    function automatic int wrapw(input int v, input int w);
        return (v <<< (32 - w)) >>> (32 - w);
    endfunction

    function automatic void cordic_ref(input int xi, input int yi, input int ai,
                                       output int xo, output int yo, output int zo);
        int x, y, z, xn;
        x = xi; y = yi; z = ai;
        for (int i = 0; i < ITERS; i++) begin
            if (z >= 0) begin
                xn = x - (y >>> i);
                y  = y + (x >>> i);
                z  = z - atan_tab[i];
            end else begin
                xn = x + (y >>> i);
                y  = y - (x >>> i);
                z  = z + atan_tab[i];
            end
            x = wrapw(xn, XY_W);
            y = wrapw(y, XY_W);
            z = wrapw(z, Z_W);
        end
        xo = x; yo = y; zo = z;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input int exp, input int tol);
        int d;
        n_chk++;
        d = act - exp;
        if (d < -tol || d > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d +-%0d at %0t", name, act, exp, tol, $time);
        end
    endtask

    // Reference: phase = cycles since acceptance (0 when idle); results appear when phase reaches LAT.
    int ph = 0;
    int ex_x = 0, ex_y = 0, ex_z = 0;
    int pd_x = 0, pd_y = 0, pd_z = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph   = 0;
            ex_x = 0; ex_y = 0; ex_z = 0;
        end else if (ph == 0 || ph == LAT) begin
            if (bus.start) begin
                ph = 1;
                cordic_ref(int'(bus.x_in), int'(bus.y_in), int'(bus.angle_in), pd_x, pd_y, pd_z);
            end else begin
                ph = 0;
            end
        end else if (ph == LAT - 1) begin
            ph   = LAT;
            ex_x = pd_x; ex_y = pd_y; ex_z = pd_z;
        end else begin
            ph = ph + 1;
        end
    end

    always @(negedge clk) begin
        int busy_e, en_e;
        busy_e = (ph >= 1 && ph <= LAT - 1) ? 1 : 0;
        en_e   = (ph >= 1 && ph <= ITERS) ? 1 : 0;
        chk("busy", int'(bus.busy), busy_e);
        chk("ready", int'(bus.ready), 1 - busy_e);
        chk("done", int'(bus.done), (ph == LAT) ? 1 : 0);
        chk("rom_en", int'(rom_en), en_e);
        chk("rom_addr", int'(rom_addr), (en_e != 0) ? ph - 1 : 0);
        chk("x_out", int'(bus.x_out), ex_x);
        chk("y_out", int'(bus.y_out), ex_y);
        chk("z_out", int'(bus.z_out), ex_z);
    end

    task automatic drive(input int x, input int y, input int a);
        bus.x_in     = XY_W'(x);
        bus.y_in     = XY_W'(y);
        bus.angle_in = Z_W'(a);
    endtask

    // Issues one operation at a negedge and returns the cycle count to done plus the results.
    task automatic run_op(input int x, input int y, input int a, output int lat,
                          output int en_cnt, output int xo, output int yo, output int zo);
        int k;
        k = 0;
        while (!bus.ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!bus.ready) chk("ready_wait", 0, 1);
        drive(x, y, a);
        bus.start = 1'b1;
        lat = -1; en_cnt = 0; xo = 0; yo = 0; zo = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (rom_en) en_cnt++;
            if (bus.done) begin
                lat = c;
                xo  = int'(bus.x_out);
                yo  = int'(bus.y_out);
                zo  = int'(bus.z_out);
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int lat, en_cnt, xo, yo, zo, mx, my, mz;
        $display("angle LSB = 2^%0d rad, K = %0d/32768, 1/K = %0d/32768",
                 CORDIC_Z_LSB_EXP, CORDIC_K_Q15, CORDIC_INV_K_Q15);
        bus.start = 1'b0;
        drive(0, 0, 0);

        repeat (3) @(negedge clk);
        chk("rst_ready", int'(bus.ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_rom_en", int'(rom_en), 0);
        chk("rst_x_out", int'(bus.x_out), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Hand-computed values that the reference model must agree with.
        cordic_ref(19898, 0, 17157, mx, my, mz);
        chk_tol("model_pi6_x", mx, 28378, 16);
        chk_tol("model_pi6_y", my, 16384, 16);

        run_op(CORDIC_INV_K_Q15, 0, 0, lat, en_cnt, xo, yo, zo);
        chk("zero_latency", lat, LAT);
        chk("zero_rom_en_cycles", en_cnt, ITERS);
        chk_tol("zero_x", xo, 32768, 16);
        chk_tol("zero_y", yo, 0, 16);
        chk_tol("zero_z", zo, 0, 4);

        repeat (2) @(negedge clk);
        run_op(19898, 0, 17157, lat, en_cnt, xo, yo, zo);
        chk("pi6_latency", lat, LAT);
        chk_tol("pi6_x", xo, 28378, 16);
        chk_tol("pi6_y", yo, 16384, 16);

        run_op(19898, 0, -25736, lat, en_cnt, xo, yo, zo);
        chk("neg_latency", lat, LAT);
        chk("neg_rom_en_cycles", en_cnt, ITERS);
        chk_tol("neg_x", xo, 23170, 16);
        chk_tol("neg_y", yo, -23170, 16);

        // start held through busy, new operands presented in the done cycle.
        repeat (3) @(negedge clk);
        drive(19898, 0, 0);
        bus.start = 1'b1;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 4) drive(-7000, 5000, 40000);
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        chk("hold_first_latency", lat, LAT);
        chk_tol("hold_first_x", int'(bus.x_out), 32768, 16);
        drive(19898, 0, 17157);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        chk("b2b_latency", lat, LAT);
        chk_tol("b2b_x", int'(bus.x_out), 28378, 16);
        chk_tol("b2b_y", int'(bus.y_out), 16384, 16);

        // Randomized traffic, checked cycle by cycle against the reference.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) != 0);
            drive(int'($urandom_range(0, 39796)) - 19898,
                  int'($urandom_range(0, 39796)) - 19898,
                  int'($urandom_range(0, 114032)) - 57016);
        end
        bus.start = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        // Reset in the middle of an iteration abandons the operation.
        drive(19898, 0, 17157);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rom_en", int'(rom_en), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_ready", int'(bus.ready), 1);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_x_out", int'(bus.x_out), 0);
        chk("midrst_y_out", int'(bus.y_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.done) lat++;
        end
        chk("midrst_no_done", lat, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
